// File: rtl/rxb_burst_collector.sv
// rxb_burst_collector: requests a domain-B burst, packs returned bytes little-endian into 32-bit words, buffers them in a FWFT FIFO
// Ports: clkb/resetb_clkb (async active-low reset); start_clkb trigger; data_req_clkb one-cycle request;
//   data_valid_clkb/dout_clkb byte input; word_valid/ready/data/keep/last_clkb output stream;
//   busy_clkb, done_clkb pulse, sticky timeout_clkb/ovf_clkb/seq_err_clkb.
// Optional: define RXB_SEQ_CHECK_EN to flag bytes that do not increment by 1 (mod 256) within a burst.
module rxb_burst_collector #(
  parameter int BURST_LEN = 21,
  parameter int TIMEOUT = 64,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clkb,
  input  logic        resetb_clkb,
  input  logic        start_clkb,
  output logic        data_req_clkb,
  input  logic        data_valid_clkb,
  input  logic [7:0]  dout_clkb,
  output logic        word_valid_clkb,
  input  logic        word_ready_clkb,
  output logic [31:0] word_data_clkb,
  output logic [3:0]  word_keep_clkb,
  output logic        word_last_clkb,
  output logic        busy_clkb,
  output logic        done_clkb,
  output logic        timeout_clkb,
  output logic        ovf_clkb,
  output logic        seq_err_clkb
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_COLL = 2'd3;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(OUT_DEPTH);
  logic [1:0]    state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tmr, tmr_inc;
  logic [1:0]    lane;
  logic [31:0]   pk_data, ins_data;
  logic [3:0]    pk_keep, ins_keep;
  logic          st_vld;
  logic [36:0]   st_word;
  logic [36:0]   mem [OUT_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          collecting, take, is_last, expire, full, empty, pop, push_ok;
  assign collecting = (state == S_WAIT) || (state == S_COLL);
  assign take       = collecting && data_valid_clkb;
  assign cnt_nxt    = cnt + 1'b1;
  assign is_last    = cnt_nxt == CW'(BURST_LEN);
  assign ins_data   = pk_data | ({24'd0, dout_clkb} << {lane, 3'b000});
  assign ins_keep   = pk_keep | (4'b0001 << lane);
  assign tmr_inc    = (tmr == TW'(TIMEOUT)) ? tmr : tmr + 1'b1;
  assign expire     = collecting && !data_valid_clkb && (tmr_inc == TW'(TIMEOUT));
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && word_ready_clkb;
  // a full FIFO still accepts the staged word when the head leaves in the same cycle
  assign push_ok    = st_vld && (!full || pop);
  assign data_req_clkb   = state == S_REQ;
  assign busy_clkb       = state != S_IDLE;
  assign word_valid_clkb = !empty;
  assign {word_data_clkb, word_keep_clkb, word_last_clkb} = empty ? 37'd0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clkb or negedge resetb_clkb) begin
    if (!resetb_clkb) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tmr          <= '0;
      lane         <= '0;
      pk_data      <= '0;
      pk_keep      <= '0;
      st_vld       <= 1'b0;
      st_word      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      done_clkb    <= 1'b0;
      timeout_clkb <= 1'b0;
      ovf_clkb     <= 1'b0;
    end else begin
      done_clkb <= 1'b0;
      st_vld    <= 1'b0;
      if (state == S_IDLE) begin
        if (start_clkb) begin
          state        <= S_REQ;
          cnt          <= '0;
          tmr          <= '0;
          lane         <= '0;
          pk_data      <= '0;
          pk_keep      <= '0;
          timeout_clkb <= 1'b0;
          ovf_clkb     <= 1'b0;
        end
      end else if (state == S_REQ) begin
        state <= S_WAIT;
      end else if (take) begin
        cnt   <= cnt_nxt;
        lane  <= lane + 2'd1;
        tmr   <= '0;
        state <= is_last ? S_IDLE : S_COLL;
        done_clkb <= is_last;
        // completed words go to a staging register so the packer can take the next byte immediately
        if (lane == 2'd3 || is_last) begin
          st_vld  <= 1'b1;
          st_word <= {ins_data, ins_keep, is_last};
          pk_data <= '0;
          pk_keep <= '0;
        end else begin
          pk_data <= ins_data;
          pk_keep <= ins_keep;
        end
      end else if (expire) begin
        state        <= S_IDLE;
        timeout_clkb <= 1'b1;
        st_vld       <= pk_keep != 4'd0;
        st_word      <= {pk_data, pk_keep, 1'b1};
        pk_data      <= '0;
        pk_keep      <= '0;
      end else begin
        tmr <= tmr_inc;
      end
      if (st_vld && full && !pop) ovf_clkb <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clkb) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= st_word;
  end
`ifdef RXB_SEQ_CHECK_EN
  logic [7:0] prev;
  logic       seq_r;
  always_ff @(posedge clkb or negedge resetb_clkb) begin
    if (!resetb_clkb) begin
      prev  <= '0;
      seq_r <= 1'b0;
    end else if (state == S_IDLE && start_clkb) begin
      seq_r <= 1'b0;
    end else if (take) begin
      prev <= dout_clkb;
      if (state == S_COLL && dout_clkb != prev + 8'd1) seq_r <= 1'b1;
    end
  end
  assign seq_err_clkb = seq_r;
`else
  assign seq_err_clkb = 1'b0;
`endif
endmodule

// File: tb/tb_rxb_burst_collector.sv
// tb_rxb_burst_collector: directed table-driven bench for rxb_burst_collector
module tb_rxb_burst_collector;
  localparam int BL = 21, TO = 64, DEPTH = 4;
  logic clkb = 1'b0, resetb_clkb = 1'b0, start_clkb = 1'b0, data_valid_clkb = 1'b0, word_ready_clkb = 1'b0;
  logic [7:0] dout_clkb = 8'd0;
  logic data_req_clkb, word_valid_clkb, word_last_clkb, busy_clkb, done_clkb, timeout_clkb, ovf_clkb, seq_err_clkb;
  logic [31:0] word_data_clkb;
  logic [3:0] word_keep_clkb;
  rxb_burst_collector #(.BURST_LEN(BL), .TIMEOUT(TO), .OUT_DEPTH(DEPTH)) dut (
    .clkb(clkb), .resetb_clkb(resetb_clkb), .start_clkb(start_clkb), .data_req_clkb(data_req_clkb),
    .data_valid_clkb(data_valid_clkb), .dout_clkb(dout_clkb), .word_valid_clkb(word_valid_clkb),
    .word_ready_clkb(word_ready_clkb), .word_data_clkb(word_data_clkb), .word_keep_clkb(word_keep_clkb),
    .word_last_clkb(word_last_clkb), .busy_clkb(busy_clkb), .done_clkb(done_clkb),
    .timeout_clkb(timeout_clkb), .ovf_clkb(ovf_clkb), .seq_err_clkb(seq_err_clkb)
  );
  always #5 clkb = ~clkb;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  typedef struct {
    int n; logic [7:0] first; logic ready; int words;
    logic [31:0] last_d; logic [3:0] last_k; logic last_l;
    int done; logic to; logic ovf;
  } row_t;
  word_t rx[$];
  int n_done = 0, n_req = 0;
  int checks = 0, errors = 0;
  logic [7:0] tx[256];
  row_t rows[5];
  always @(negedge clkb) begin
    if (resetb_clkb) begin
      if (word_valid_clkb && word_ready_clkb) rx.push_back({word_data_clkb, word_keep_clkb, word_last_clkb});
      if (done_clkb) n_done++;
      if (data_req_clkb) n_req++;
    end
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic start_burst();
    start_clkb = 1'b1;
    @(posedge clkb); #1;
    start_clkb = 1'b0;
    @(posedge clkb); #1;
  endtask
  task automatic send(int n);
    for (int i = 0; i < n; i++) begin
      data_valid_clkb = 1'b1;
      dout_clkb = tx[i];
      @(posedge clkb); #1;
    end
    data_valid_clkb = 1'b0;
    dout_clkb = 8'd0;
  endtask
  task automatic wait_idle(int budget);
    int k = 0;
    while (busy_clkb && k < budget) begin
      @(posedge clkb); #1;
      k++;
    end
    chk("idle_wait", 64'(busy_clkb), 64'd0);
  endtask
  task automatic drain();
    repeat (3) begin @(posedge clkb); #1; end
    word_ready_clkb = 1'b1;
    repeat (DEPTH + 6) begin @(posedge clkb); #1; end
  endtask
  task automatic model_chk(string nm, int n, int base, int maxw);
    word_t exp[$];
    logic [31:0] d = '0;
    logic [3:0] k = '0;
    for (int i = 0; i < n; i++) begin
      d[8*(i%4) +: 8] = tx[i];
      k[i%4] = 1'b1;
      if (i % 4 == 3 || i == BL - 1) begin
        exp.push_back({d, k, i == BL - 1});
        d = '0;
        k = '0;
      end
    end
    if (k != 4'd0) exp.push_back({d, k, 1'b1});
    for (int i = 0; i < exp.size() && i < maxw && base + i < rx.size(); i++)
      chk(nm, 64'(rx[base+i]), 64'(exp[i]));
  endtask
  task automatic run_row(int idx);
    row_t r = rows[idx];
    int b_rx = rx.size(), b_done = n_done, b_req = n_req;
    word_t lw;
    for (int i = 0; i < r.n; i++) tx[i] = r.first + 8'(i);
    word_ready_clkb = r.ready;
    start_burst();
    send(r.n);
    wait_idle(r.to ? TO + 8 : 8);
    drain();
    chk($sformatf("row%0d_words", idx), 64'(rx.size() - b_rx), 64'(r.words));
    if (rx.size() > b_rx) begin
      lw = rx[rx.size()-1];
      chk($sformatf("row%0d_last_word", idx), 64'(lw), 64'({r.last_d, r.last_k, r.last_l}));
    end
    model_chk($sformatf("row%0d_word", idx), r.n, b_rx, r.words);
    chk($sformatf("row%0d_done", idx), 64'(n_done - b_done), 64'(r.done));
    chk($sformatf("row%0d_req", idx), 64'(n_req - b_req), 64'd1);
    chk($sformatf("row%0d_timeout", idx), 64'(timeout_clkb), 64'(r.to));
    chk($sformatf("row%0d_ovf", idx), 64'(ovf_clkb), 64'(r.ovf));
    chk($sformatf("row%0d_empty", idx), 64'(word_valid_clkb), 64'd0);
  endtask
  initial begin
    int b_rx, b_done, b_req;
    logic exp_seq;
    rows[0] = '{21, 8'h01, 1'b1, 6, 32'h00000015, 4'h1, 1'b1, 1, 1'b0, 1'b0};
    rows[1] = '{10, 8'h01, 1'b1, 3, 32'h00000A09, 4'h3, 1'b1, 0, 1'b1, 1'b0};
    rows[2] = '{21, 8'h01, 1'b0, 4, 32'h100F0E0D, 4'hF, 1'b0, 1, 1'b0, 1'b1};
    rows[3] = '{21, 8'hF0, 1'b1, 6, 32'h00000004, 4'h1, 1'b1, 1, 1'b0, 1'b0};
    rows[4] = '{4,  8'hA0, 1'b1, 1, 32'hA3A2A1A0, 4'hF, 1'b0, 0, 1'b1, 1'b0};
    #1;
    chk("reset_outs", 64'({word_valid_clkb, busy_clkb, data_req_clkb, done_clkb, timeout_clkb,
        ovf_clkb, seq_err_clkb, word_keep_clkb, word_last_clkb}), 64'd0);
    chk("reset_data", 64'(word_data_clkb), 64'd0);
    repeat (2) @(posedge clkb);
    #1 resetb_clkb = 1'b1;
    @(posedge clkb); #1;
    for (int i = 0; i < 5; i++) run_row(i);
    b_rx = rx.size(); b_done = n_done; b_req = n_req;
    word_ready_clkb = 1'b1;
    start_clkb = 1'b1;
    @(posedge clkb); #1;
    start_clkb = 1'b0;
    repeat (64) @(posedge clkb);
    @(negedge clkb);
    chk("to_busy_before", 64'({busy_clkb, timeout_clkb}), 64'b10);
    @(posedge clkb);
    @(negedge clkb);
    chk("to_busy_after", 64'({busy_clkb, timeout_clkb}), 64'b01);
    repeat (4) @(posedge clkb);
    #1;
    chk("to_no_words", 64'(rx.size() - b_rx), 64'd0);
    chk("to_no_done", 64'(n_done - b_done), 64'd0);
    chk("to_one_req", 64'(n_req - b_req), 64'd1);
    for (int i = 0; i < BL; i++) tx[i] = 8'(i + 1);
    word_ready_clkb = 1'b0;
    start_burst();
    send(7);
    chk("pre_reset_valid", 64'(word_valid_clkb), 64'd1);
    #2 resetb_clkb = 1'b0;
    #1;
    chk("midrst_outs", 64'({word_valid_clkb, busy_clkb, data_req_clkb, done_clkb, timeout_clkb,
        ovf_clkb, seq_err_clkb, word_keep_clkb, word_last_clkb}), 64'd0);
    chk("midrst_data", 64'(word_data_clkb), 64'd0);
    #2 resetb_clkb = 1'b1;
    @(posedge clkb); #1;
    chk("midrst_fifo_empty", 64'(word_valid_clkb), 64'd0);
    run_row(0);
`ifdef RXB_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    tx[0] = 8'd254; tx[1] = 8'd255; tx[2] = 8'd0;
    for (int i = 3; i < BL; i++) tx[i] = 8'(i - 1);
    b_rx = rx.size();
    word_ready_clkb = 1'b1;
    start_burst();
    for (int i = 0; i < BL; i++) begin
      data_valid_clkb = 1'b1;
      dout_clkb = tx[i];
      @(posedge clkb); #1;
      if (i == 2) chk("seq_wrap_ok", 64'(seq_err_clkb), 64'd0);
      if (i == 3) chk("seq_err_set", 64'(seq_err_clkb), 64'(exp_seq));
    end
    data_valid_clkb = 1'b0;
    dout_clkb = 8'd0;
    wait_idle(8);
    drain();
    chk("seq_words", 64'(rx.size() - b_rx), 64'd6);
    model_chk("seq_word", BL, b_rx, 6);
    chk("seq_sticky", 64'(seq_err_clkb), 64'(exp_seq));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
